// File: rtl/cart_mbc1.sv
// MBC1 cartridge bank controller.
// CPU writes to 0000-7FFF program the bank registers. CPU addresses are
// translated into physical ROM and external-RAM byte addresses, and the
// selects that tell the cartridge arrays when to respond are generated.
module cart_mbc1 #(
  parameter int ROM_BANKS = 64,
  parameter int RAM_BANKS = 4,
  localparam int RA = $clog2(ROM_BANKS) + 14,
  localparam int RB = $clog2((RAM_BANKS > 1) ? RAM_BANKS : 1) + 13
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [15:0]   addr,
  input  logic [7:0]    data_w,
  input  logic          write_enable,
  output logic [RA-1:0] rom_addr,
  output logic          rom_cs,
  output logic [RB-1:0] ram_addr,
  output logic          ram_cs,
  output logic          ram_we,
  output logic          data_active
);

  localparam int ROM_BW  = RA - 14;
  localparam int RAM_BW  = RB - 13;
  localparam bit HAS_RAM = (RAM_BANKS > 0);

  logic       ram_en;
  logic [4:0] rom_lo;
  logic [1:0] bank_hi;
  logic       mode;
  logic       we_q;

  logic       wr_edge;
  logic       in_rom;
  logic       in_ram;
  logic [6:0] rom_bank;
  logic       unused;

  // we_q resets high, so a strobe that is already asserted when reset is
  // released is treated as "already seen" and never commits.
  assign wr_edge = write_enable & ~we_q;
  assign in_rom  = ~addr[15];
  assign in_ram  = (addr[15:13] == 3'b101);

  // Strobe edge tracking and bank-register commit on the first cycle of a write.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_en  <= 1'b0;
      rom_lo  <= 5'd0;
      bank_hi <= 2'd0;
      mode    <= 1'b0;
      we_q    <= 1'b1;
    end else begin
      we_q <= write_enable;
      if (wr_edge && in_rom) begin
        unique case (addr[14:13])
          2'b00: ram_en  <= (data_w[3:0] == 4'hA);
          2'b01: rom_lo  <= data_w[4:0];
          2'b10: bank_hi <= data_w[1:0];
          2'b11: mode    <= data_w[0];
        endcase
      end
    end
  end

  // ROM bank select: the fixed window follows bank_hi only in mode 1; the
  // switchable window remaps a zero low field to 1 (5-bit field test only).
  // NOTE: default assignment first so no path leaves rom_bank unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    rom_bank = 7'd0;
    if (addr[14]) begin
      rom_bank = {bank_hi, (rom_lo == 5'd0) ? 5'd1 : rom_lo};
    end else if (mode) begin
      rom_bank = {bank_hi, 5'd0};
    end
  end

  // ROM_BANKS is a power of two, so masking the bank is keeping its low bits.
  assign rom_addr = {rom_bank[ROM_BW-1:0], addr[13:0]};

  generate
    if (RAM_BANKS > 1) begin : g_banked_ram
      logic [1:0] ram_bank;
      assign ram_bank = mode ? bank_hi : 2'd0;
      assign ram_addr = {ram_bank[RAM_BW-1:0], addr[12:0]};
    end else begin : g_flat_ram
      assign ram_addr = addr[12:0];
    end
  endgenerate

  // Selects are purely combinational; ram_we sees the pre-commit ram_en,
  // so a disable write only takes effect on the following cycle.
  assign rom_cs      = ~write_enable & in_rom;
  assign ram_cs      = HAS_RAM & ram_en & in_ram;
  assign ram_we      = ram_cs & wr_edge;
  assign data_active = rom_cs | (ram_cs & ~write_enable);

  // Upper data bits and bank bits above the fitted ROM size are ignored.
  assign unused = ^{data_w[7:5], rom_bank};

endmodule

// File: tb/tb_cart_mbc1.sv
// Directed bench for cart_mbc1: a 64-bank/4-RAM-bank instance plus an
// 8-ROM-bank instance fed the same bus, checked against hand-computed values.
module tb_cart_mbc1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] addr;
  logic [7:0]  data_w;
  logic        write_enable;

  logic [19:0] rom_addr;
  logic        rom_cs;
  logic [14:0] ram_addr;
  logic        ram_cs;
  logic        ram_we;
  logic        data_active;

  logic [16:0] rom_addr8;
  logic        rom_cs8;
  logic [14:0] ram_addr8;
  logic        ram_cs8;
  logic        ram_we8;
  logic        data_active8;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  cart_mbc1 #(.ROM_BANKS(64), .RAM_BANKS(4)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .data_w(data_w),
    .write_enable(write_enable), .rom_addr(rom_addr), .rom_cs(rom_cs),
    .ram_addr(ram_addr), .ram_cs(ram_cs), .ram_we(ram_we),
    .data_active(data_active)
  );

  cart_mbc1 #(.ROM_BANKS(8), .RAM_BANKS(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .addr(addr), .data_w(data_w),
    .write_enable(write_enable), .rom_addr(rom_addr8), .rom_cs(rom_cs8),
    .ram_addr(ram_addr8), .ram_cs(ram_cs8), .ram_we(ram_we8),
    .data_active(data_active8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // One-cycle write strobe: driven on a falling edge, committed on the next rising edge.
  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = a; data_w = d; write_enable = 1'b1;
    @(negedge clk);
    write_enable = 1'b0;
  endtask

  // Present a read address and let combinational outputs settle.
  task automatic bus_read(input logic [15:0] a);
    @(negedge clk);
    addr = a; write_enable = 1'b0;
    #1;
  endtask

  initial begin
    int pulses;
    rst_n = 1'b0; addr = 16'h0000; data_w = 8'h00; write_enable = 1'b0;
    #12;
    check("rst_ram_we", ram_we, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: reset mapping
    bus_read(16'h4000);
    check("t1_rom_addr", rom_addr, 32'h04000);
    check("t1_rom_cs", rom_cs, 1);
    check("t1_data_active", data_active, 1);
    bus_read(16'h0000);
    check("t1_bank0", rom_addr, 32'h00000);
    bus_read(16'hA000);
    check("t1_ram_cs", ram_cs, 0);
    check("t1_ram_da", data_active, 0);

    // 2: rom_lo zero remap, then bank 5
    bus_write(16'h2000, 8'h00);
    bus_read(16'h4000);
    check("t2_remap", rom_addr, 32'h04000);
    bus_write(16'h2000, 8'h05);
    bus_read(16'h4123);
    check("t2_bank5", rom_addr, 32'h14123);

    // 3: 21h remap, mode 0 / mode 1 fixed window
    bus_write(16'h4000, 8'h01);
    bus_write(16'h2000, 8'h00);
    bus_read(16'h4000);
    check("t3_bank21", rom_addr, 32'h84000);
    bus_read(16'h0010);
    check("t3_mode0_low", rom_addr, 32'h00010);
    bus_write(16'h6000, 8'h01);
    bus_read(16'h0010);
    check("t3_mode1_low", rom_addr, 32'h80010);

    // 4: bank masking (bank 3Fh)
    bus_write(16'h2000, 8'h1F);
    bus_read(16'h4000);
    check("t4_mask8", rom_addr8, 32'h1C000);
    check("t4_bank3f", rom_addr, 32'hFC000);
    bus_read(16'h8000);
    check("t4_8000_cs", rom_cs, 0);
    check("t4_8000_da", data_active, 0);
    bus_read(16'h7FFF);
    check("t4_7fff_cs", rom_cs, 1);

    // 5: RAM disabled write dropped, then enabled banked write
    @(negedge clk);
    addr = 16'hA000; data_w = 8'h11; write_enable = 1'b1;
    #1;
    check("t5_dis_we", ram_we, 0);
    check("t5_dis_da", data_active, 0);
    check("t5_wr_rom_cs", rom_cs, 0);
    @(negedge clk);
    write_enable = 1'b0;
    bus_write(16'h0000, 8'h0A);
    bus_write(16'h4000, 8'h02);
    @(negedge clk);
    addr = 16'hA005; data_w = 8'h55; write_enable = 1'b1;
    #1;
    check("t5_ram_addr", ram_addr, 32'h4005);
    check("t5_ram_cs_wr", ram_cs, 1);
    check("t5_wr_da", data_active, 0);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      if (ram_we) pulses++;
      @(negedge clk);
      #1;
    end
    write_enable = 1'b0;
    check("t5_pulses", pulses, 1);
    bus_read(16'hBFFF);
    check("t5_bfff_cs", ram_cs, 1);
    check("t5_bfff_da", data_active, 1);
    bus_read(16'hC000);
    check("t5_c000_cs", ram_cs, 0);
    bus_write(16'h0000, 8'h0B);
    bus_read(16'hA000);
    check("t5_disabled", ram_cs, 0);

    // 6: long strobe commits only the first data value
    @(negedge clk);
    addr = 16'h2000; data_w = 8'h03; write_enable = 1'b1;
    for (int i = 4; i <= 7; i++) begin
      @(negedge clk);
      data_w = 8'(i);
    end
    write_enable = 1'b0;
    bus_read(16'h4000);
    check("t6_long_strobe", rom_addr, 32'h0C000);

    // 6: reset mid-strobe, release with strobe high
    @(negedge clk);
    addr = 16'h2000; data_w = 8'h09; write_enable = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    data_w = 8'h0B;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    write_enable = 1'b0;
    bus_read(16'h4000);
    check("t6_rst_rom_lo", rom_addr, 32'h04000);
    bus_read(16'h0000);
    check("t6_rst_mode", rom_addr, 32'h00000);
    bus_read(16'hA000);
    check("t6_rst_ram_en", ram_cs, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
